// File: rtl/prn_sched_pkg.sv
// Shared types and widths for the PRN-code correlator slot scheduler.
package prn_sched_pkg;
  localparam int PRN_ST_W = 12;
  localparam int PRN1_W   = 8;
  localparam int PRN2_W   = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    LOAD = 3'd2,
    RUN  = 3'd3,
    SAVE = 3'd4
  } prn_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the caller registers grant and next_ptr.
// COR_SCHED_PRIORITY_EN: channel 0 wins outright and the pointer is left alone.
module rr_arbiter #(
  parameter int CH_NUM = 4,
  localparam int AW = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [AW-1:0]     ptr,
  input  logic              en,
  output logic [CH_NUM-1:0] grant,
  output logic [AW-1:0]     grant_idx,
  output logic [AW-1:0]     next_ptr
);
  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    next_ptr  = ptr;
    found     = 1'b0;
    idx       = 0;
    if (en) begin
      // Rotate the search so the first requester at or after ptr wins.
      for (int i = 0; i < CH_NUM; i++) begin
        idx = (int'(ptr) + i) % CH_NUM;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = AW'(idx);
          next_ptr   = AW'((idx + 1) % CH_NUM);
        end
      end
`ifdef COR_SCHED_PRIORITY_EN
      if (req[0]) begin
        grant     = '0;
        grant[0]  = 1'b1;
        grant_idx = '0;
        next_ptr  = ptr;
      end
`else
`endif
    end
  end
endmodule

// File: rtl/prn_state_sched.sv
// Time-multiplexes one PRN correlator among CH_NUM channels: arbitrate, read, load, run, save.
// Optional build macro COR_SCHED_PRIORITY_EN gives channel 0 absolute priority (in rr_arbiter).
module prn_state_sched
  import prn_sched_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 10,
  localparam int AW = $clog2(CH_NUM)
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [CH_NUM-1:0]   ch_req,
  input  logic [CNT_W-1:0]    sample_num,
  input  logic                overflow,
  output logic [CH_NUM-1:0]   ch_grant,
  output logic                busy,
  output logic                cor_active,
  output logic                st_rd_en,
  output logic                st_wr_en,
  output logic [AW-1:0]       st_addr,
  input  logic [PRN_ST_W-1:0] st_rdata,
  output logic [PRN_ST_W-1:0] st_wdata,
  output logic                prn_code_load_en,
  output logic                corr_state_load_en,
  output logic [PRN1_W-1:0]   prn_code_i,
  output logic [PRN2_W-1:0]   prn_code2_i,
  input  logic [PRN1_W-1:0]   prn_code_o,
  input  logic [PRN2_W-1:0]   prn_code2_o,
  output logic                ch_done,
  output logic [AW-1:0]       ch_done_id,
  output prn_state_e          state_dbg
);
  // Handshake: a level on ch_req is served once per slot; ch_done/st_wr_en pulse
  // together for one cycle in SAVE, and the requester is re-arbitrated in IDLE.
  prn_state_e         state, state_nxt;
  logic [AW-1:0]      rr_ptr, addr_q;
  logic [CH_NUM-1:0]  grant_q;
  logic [CNT_W-1:0]   cnt, samp_q;
  logic [CH_NUM-1:0]  arb_grant;
  logic [AW-1:0]      arb_idx, arb_next;
  logic               take;

  assign take = (state == IDLE) && (|ch_req);

  rr_arbiter #(.CH_NUM(CH_NUM)) u_arb (
    .req       (ch_req),
    .ptr       (rr_ptr),
    .en        (state == IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .next_ptr  (arb_next)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      addr_q  <= '0;
      grant_q <= '0;
      cnt     <= '0;
      samp_q  <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        grant_q <= arb_grant;
        addr_q  <= arb_idx;
        rr_ptr  <= arb_next;
        samp_q  <= sample_num;
      end
      if (state == SAVE) grant_q <= '0;
      // Overflows outside RUN never reach the counter.
      if (state == LOAD) cnt <= samp_q;
      else if ((state == RUN) && overflow) cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|ch_req) state_nxt = READ;
      READ: state_nxt = LOAD;
      LOAD: state_nxt = (samp_q != '0) ? RUN : SAVE;
      RUN:  if (overflow && (cnt == CNT_W'(1))) state_nxt = SAVE;
      SAVE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy               = (state != IDLE);
    cor_active         = (state == RUN);
    st_rd_en           = (state == READ);
    prn_code_load_en   = (state == LOAD);
    corr_state_load_en = (state == LOAD);
    st_wr_en           = (state == SAVE);
    ch_done            = (state == SAVE);
    st_wdata           = (state == SAVE) ? {prn_code_o, prn_code2_o} : '0;
    ch_done_id         = (state == SAVE) ? addr_q : '0;
  end

  assign ch_grant    = grant_q;
  assign st_addr     = addr_q;
  assign prn_code_i  = st_rdata[PRN_ST_W-1:PRN2_W];
  assign prn_code2_i = st_rdata[PRN2_W-1:0];
  assign state_dbg   = state;
endmodule

// File: tb/tb_prn_state_sched.sv
// Scoreboarded bench for prn_state_sched with RAM and correlator environment models.
module tb_prn_state_sched;
  import prn_sched_pkg::*;
  localparam int CH = 4;
  localparam int AW = 2;
  localparam int CW = 10;
  localparam int XW = AW + 12 + CH + 16;

  logic clk, rst_b;
  logic [CH-1:0] ch_req, ch_grant;
  logic [CW-1:0] sample_num;
  logic overflow, busy, cor_active, st_rd_en, st_wr_en;
  logic [AW-1:0] st_addr, ch_done_id;
  logic [11:0] st_rdata, st_wdata;
  logic prn_code_load_en, corr_state_load_en, ch_done;
  logic [7:0] prn_code_i, prn_code_o;
  logic [3:0] prn_code2_i, prn_code2_o;
  prn_state_e state_dbg;

  prn_state_sched #(.CH_NUM(CH), .CNT_W(CW)) dut (
    .clk(clk), .rst_b(rst_b), .ch_req(ch_req), .sample_num(sample_num),
    .overflow(overflow), .ch_grant(ch_grant), .busy(busy), .cor_active(cor_active),
    .st_rd_en(st_rd_en), .st_wr_en(st_wr_en), .st_addr(st_addr), .st_rdata(st_rdata),
    .st_wdata(st_wdata), .prn_code_load_en(prn_code_load_en),
    .corr_state_load_en(corr_state_load_en), .prn_code_i(prn_code_i),
    .prn_code2_i(prn_code2_i), .prn_code_o(prn_code_o), .prn_code2_o(prn_code2_o),
    .ch_done(ch_done), .ch_done_id(ch_done_id), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- environment: state RAM and correlator ----------------
  logic [11:0] ram [CH];
  logic [11:0] ref_ram [CH];
  logic [11:0] cor_st;

  function automatic logic [11:0] step(input logic [11:0] x);
    return {x[10:0], x[11] ^ x[6] ^ x[3] ^ 1'b1};
  endfunction

  always @(posedge clk) begin
    if (st_rd_en) st_rdata <= ram[st_addr];
    if (st_wr_en) ram[st_addr] <= st_wdata;
    if (prn_code_load_en) cor_st <= {prn_code_i, prn_code2_i};
    else if (cor_active && overflow) cor_st <= step(cor_st);
  end
  assign prn_code_o  = cor_st[11:4];
  assign prn_code2_o = cor_st[3:0];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [XW-1:0] exp_q[$];
  int m_ptr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration: lowest requester at or after the pointer (ch0 first if prioritised).
  task automatic model_pick(input logic [CH-1:0] m, output int w);
    w = -1;
`ifdef COR_SCHED_PRIORITY_EN
    if (m[0]) begin
      w = 0;
      return;
    end
`endif
    for (int i = 0; i < CH; i++) begin
      int c;
      c = (m_ptr + i) % CH;
      if (w < 0 && m[c]) w = c;
    end
    m_ptr = (w + 1) % CH;
  endtask

  task automatic push_exp(input int w, input int snum, output logic [11:0] pre);
    logic [11:0] v;
    logic [CH-1:0] g;
    pre = ref_ram[w];
    v = pre;
    for (int k = 0; k < snum; k++) v = step(v);
    ref_ram[w] = v;
    g = '0;
    g[w] = 1'b1;
    exp_q.push_back({AW'(w), v, g, 16'(snum)});
  endtask

  // ---------------- monitor ----------------
  int ovf_cnt = 0;
  always @(negedge clk) begin
    if (!rst_b) ovf_cnt = 0;
    else begin
      if (cor_active && overflow) ovf_cnt++;
      if (st_wr_en || ch_done) chk("wr_done_align", 64'(st_wr_en), 64'(ch_done));
      if (ch_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
        else begin
          logic [XW-1:0] e;
          e = exp_q.pop_front();
          chk("done_id",   64'(ch_done_id), 64'(e[XW-1 -: AW]));
          chk("wdata",     64'(st_wdata),   64'(e[16+CH +: 12]));
          chk("grant",     64'(ch_grant),   64'(e[16 +: CH]));
          chk("ovf_count", 64'(ovf_cnt),    64'(e[15:0]));
        end
        ovf_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("busy_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_slot(input logic [CH-1:0] mask, input int snum, input bit drop);
    int w;
    bit ok;
    logic [11:0] pre;
    logic [CH-1:0] g;
    @(posedge clk); #1;
    ch_req = mask;
    sample_num = CW'(snum);
    overflow = 1'($urandom_range(0, 1));
    model_pick(mask, w);
    push_exp(w, snum, pre);
    wait_busy(ok);
    if (!ok) begin
      ch_req = '0;
      return;
    end
    g = '0;
    g[w] = 1'b1;
    chk("read_grant", 64'(ch_grant), 64'(g));
    chk("read_addr",  64'(st_addr),  64'(w));
    chk("read_en",    64'(st_rd_en), 64'(1));
    overflow = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("load_en", 64'({prn_code_load_en, corr_state_load_en}), 64'(2'b11));
    chk("load_word", 64'({prn_code_i, prn_code2_i}), 64'(pre));
    if (drop) ch_req = '0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (ch_done) begin
        ok = 1'b1;
        break;
      end
      overflow = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    if (!ok) chk("done_timeout", 64'(0), 64'(1));
    ch_req = '0;
    overflow = 1'b1;
  endtask

  task automatic b2b(input logic [CH-1:0] mask, input int n);
    int w;
    bit ok;
    logic [11:0] pre;
    @(posedge clk); #1;
    ch_req = mask;
    sample_num = CW'(1);
    overflow = 1'b1;
    for (int k = 0; k < n; k++) begin
      model_pick(mask, w);
      push_exp(w, 1, pre);
    end
    for (int k = 0; k < n; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(posedge clk); #1;
        if (ch_done) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        chk("b2b_timeout", 64'(0), 64'(1));
        break;
      end
      if (k == n - 1) ch_req = '0;
      @(posedge clk); #1;
      chk("idle_gap", 64'(busy), 64'(0));
      if (k < n - 1) begin
        @(posedge clk); #1;
        chk("next_read", 64'(st_rd_en), 64'(1));
      end
    end
    overflow = 1'b0;
  endtask

  task automatic reset_mid_run(input int ch);
    bit ok;
    @(posedge clk); #1;
    ch_req = '0;
    ch_req[ch] = 1'b1;
    sample_num = CW'(5);
    overflow = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cor_active) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("run_timeout", 64'(0), 64'(1));
    overflow = 1'b1;
    @(posedge clk); #1;
    overflow = 1'b0;
    @(posedge clk); #3;
    rst_b = 1'b0;
    #1;
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_cor",   64'(cor_active), 64'(0));
    chk("rst_strb",  64'({st_rd_en, st_wr_en, ch_done, prn_code_load_en, corr_state_load_en}), 64'(0));
    chk("rst_grant", 64'(ch_grant), 64'(0));
    chk("rst_ids",   64'({st_addr, ch_done_id, st_wdata}), 64'(0));
    m_ptr = 0;
    ch_req = '0;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_b = 1'b0;
    ch_req = '0;
    sample_num = '0;
    overflow = 1'b0;
    st_rdata = '0;
    cor_st = '0;
    for (int i = 0; i < CH; i++) begin
      ram[i] = 12'($urandom);
      ref_ram[i] = ram[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy0",  64'(busy), 64'(0));
    chk("rst_strb0",  64'({st_rd_en, st_wr_en, ch_done, cor_active, prn_code_load_en}), 64'(0));
    chk("rst_grant0", 64'(ch_grant), 64'(0));
    chk("rst_ids0",   64'({st_addr, ch_done_id, st_wdata}), 64'(0));
    rst_b = 1'b1;

    b2b(4'b1111, 5);
    do_slot(4'b0100, 3, 1'b0);
    do_slot(4'b0010, 0, 1'b0);
    do_slot(4'b1000, 4, 1'b1);
    for (int t = 0; t < 14; t++)
      do_slot(CH'($urandom_range(1, 15)), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    reset_mid_run(3);
    do_slot(4'b1111, 2, 1'b1);
    b2b(4'b1111, 4);
    b2b(4'b1110, 3);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prn_state_sched.md
# prn_state_sched

Time-multiplexes one PRN-code correlator datapath among `CH_NUM` channels. Per slot it does four things in order: arbitrates among requesting channels, reads the channel's saved 12-bit code state from the state buffer, loads it into the correlator shift registers, then enables the correlator for `sample_num` code-phase overflows. At the end of the slot it writes the updated state back. It sits between the channel state RAM and the PRN-code correlator, driving that correlator's `prn_code_load_en` / `corr_state_load_en` interface.

## Interface
- CH_NUM, 4, number of channels sharing the correlator (2..16)
- CNT_W, 10, width of the per-slot overflow count
- clk  in  1  system clock
- rst_b  in  1  asynchronous active-low reset
- ch_req  in  CH_NUM  per-channel slot request (level)
- sample_num  in  CNT_W  overflows per slot, sampled at grant
- overflow  in  1  correlator code-phase overflow strobe
- ch_grant  out  CH_NUM  one-hot owner of the current slot
- busy  out  1  high in any state except IDLE
- cor_active  out  1  correlator enable, high only in RUN
- st_rd_en  out  1  state RAM read strobe
- st_wr_en  out  1  state RAM write strobe
- st_addr  out  $clog2(CH_NUM)  state RAM address (granted channel)
- st_rdata  in  12  state word; valid 1 cycle after st_rd_en
- st_wdata  out  12  {prn_code_o, prn_code2_o}
- prn_code_load_en  out  1  load pulse for 8-bit code state
- corr_state_load_en  out  1  load pulse for 4-bit 2nd-code state
- prn_code_i  out  8  st_rdata[11:4]
- prn_code2_i  out  4  st_rdata[3:0]
- prn_code_o  in  8  current correlator code state
- prn_code2_o  in  4  current 2nd-code state
- ch_done  out  1  one-cycle pulse coincident with st_wr_en
- ch_done_id  out  $clog2(CH_NUM)  channel of ch_done

## Operation
- FSM states and transitions:
  - IDLE: if any ch_req, go to READ.
  - READ: go to LOAD.
  - LOAD: go to RUN if the latched count is nonzero; otherwise go to SAVE.
  - RUN: go to SAVE when the latched count reaches 0.
  - SAVE: go to IDLE.
- Arbitration happens on the IDLE→READ transition.
  - Round-robin: search starts at rr_ptr, the lowest-index requester at or after rr_ptr wins.
  - rr_ptr becomes winner+1 (mod CH_NUM).
  - ch_grant and st_addr are latched at this point and held constant through SAVE.
- READ: st_rd_en=1 for one cycle.
- LOAD:
  - prn_code_load_en and corr_state_load_en are both 1 for one cycle.
  - prn_code_i and prn_code2_i are driven combinationally from st_rdata.
  - The remaining-overflow counter loads the sample_num value captured at grant.
- RUN: cor_active=1; the counter decrements on each overflow; exit when an overflow arrives with counter==1.
- SAVE:
  - st_wr_en=1 and st_wdata={prn_code_o, prn_code2_o}.
  - ch_done=1 and ch_done_id = granted index.
  - The saved word is exactly the state loaded in LOAD after the counted overflows.
- ch_req changes after grant are ignored until the next IDLE.
- A channel whose request is still high re-enters arbitration normally, behind the other requesters.
- overflow outside RUN is ignored.
- sample_num==0: no correlation. The unchanged state is written back, with ch_done as normal.

## Timing
- Reset values:
  - FSM=IDLE, rr_ptr=0, counter=0.
  - All strobes, cor_active, busy, ch_done = 0.
  - ch_grant=0, st_addr=0, ch_done_id=0, st_wdata=0.
- Reset asserted mid-slot aborts immediately with no write-back; state RAM keeps its previous word.
- Fixed cycles per slot: IDLE→READ 1, READ 1, LOAD 1, SAVE 1.
- RUN lasts until the Nth overflow. Minimum slot is 4 cycles plus RUN.
- Back-to-back slots: after SAVE there is one IDLE cycle before the next READ.
- ch_grant is registered and becomes valid the cycle READ is entered.

## Configuration
- COR_SCHED_PRIORITY_EN:
  - Defined: channel 0 has absolute priority. If ch_req[0] is high at arbitration it wins regardless of rr_ptr, and rr_ptr is not updated. Other channels use round-robin as above.
  - Undefined: pure round-robin for all channels.

## Structure
- Shared package prn_sched_pkg holds:
  - the FSM state enum (IDLE, READ, LOAD, RUN, SAVE)
  - PRN_ST_W=12, PRN1_W=8, PRN2_W=4
- One sub-module, rr_arbiter:
  - parameter CH_NUM
  - inputs req, ptr, en; outputs onehot grant, grant index, next_ptr
  - purely combinational; the FSM registers its result

## Test plan
- Single request ch_req=4'b0100, sample_num=3, three overflows:
  - grant=0100, st_addr=2, load pulse with prn_code_i=st_rdata[11:4].
  - cor_active for exactly 3 overflows, then st_wr_en, ch_done_id=2.
- All four requesting continuously, sample_num=1: grant order 0,1,2,3,0 with one IDLE cycle between slots.
- sample_num=0 on ch1: READ→LOAD→SAVE with no cor_active; st_wdata equals the loaded word; ch_done pulses.
- rst_b pulled low in RUN after 1 of 5 overflows: all outputs 0 within the reset edge; no st_wr_en. Next slot restarts from rr_ptr=0.
- ch_req toggled off mid-RUN and overflow pulsed during IDLE/READ: slot still completes its full count; stray overflows are not counted.
- With COR_SCHED_PRIORITY_EN and ch_req=4'b1111 held: ch0 wins every slot.
  - Drop ch_req[0]: order continues 1,2,3 from the preserved rr_ptr.
